// File: rtl/alu_seq.sv
// Registered W-bit ALU with valid/ready handshakes, persistent flags and carry-chained ops.
// Define ALU_SEQ_MULT_EN to build the multi-cycle shift-add multiplier (opcode 1011).
module alu_seq #(
  parameter int unsigned W     = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic [3:0]   S,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Out,
  output logic         C_Out,
  output logic         Overflow,
  output logic         Zero,
  output logic         Negative,
  output logic         Illegal
);

  localparam int unsigned ShW = $clog2(W);

  if ((1 << CNT_W) <= W) begin : g_cnt_check
    $error("alu_seq: CNT_W too narrow to count W multiplier steps");
  end

  typedef enum logic [1:0] {
    StIdle,
    StDone
`ifdef ALU_SEQ_MULT_EN
    , StMul
`endif
  } state_e;

  state_e         state_q;
  logic [W-1:0]   out_q;
  logic           c_q;
  logic           v_q;
  logic           z_q;
  logic           n_q;
  logic           ill_q;

  logic           accept;
  logic [W-1:0]   addend;
  logic           cin;
  logic [W:0]     sum;
  logic [ShW-1:0] sh_amt;
  logic           sh_big;
  logic [W-1:0]   res;
  logic           res_c;
  logic           res_v;
  logic           res_ill;

`ifdef ALU_SEQ_MULT_EN
  logic           is_mul;
  logic [2*W-1:0] mul_acc_q;
  logic [2*W-1:0] mul_mcand_q;
  logic [W-1:0]   mul_mplier_q;
  logic [CNT_W-1:0] mul_cnt_q;
  logic           mul_hi;
  assign mul_hi = |mul_acc_q[2*W-1:W];
`endif

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign Out       = out_q;
  assign C_Out     = c_q;
  assign Overflow  = v_q;
  assign Zero      = z_q;
  assign Negative  = n_q;
  assign Illegal   = ill_q;

  // S[0] selects subtract (invert B); S[1] chains the stored carry instead of S[0].
  always_comb begin
    addend  = S[0] ? ~B : B;
    cin     = S[1] ? c_q : S[0];
    sum     = {1'b0, A} + {1'b0, addend} + {{W{1'b0}}, cin};
    sh_amt  = B[ShW-1:0];
    sh_big  = 32'(sh_amt) >= 32'(W);
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_ill = 1'b0;
`ifdef ALU_SEQ_MULT_EN
    is_mul  = 1'b0;
`endif
    case (S)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
        res   = sum[W-1:0];
        res_c = sum[W];
        res_v = (A[W-1] == addend[W-1]) && (sum[W-1] != A[W-1]);
      end
      4'b0100: res = A & B;
      4'b0101: res = A | B;
      4'b0110: res = A ^ B;
      4'b0111: res = ~A;
      4'b1000: res = sh_big ? '0 : (A << sh_amt);
      4'b1001: res = sh_big ? '0 : (A >> sh_amt);
      4'b1010: res = sh_big ? {W{A[W-1]}} : W'($signed(A) >>> sh_amt);
`ifdef ALU_SEQ_MULT_EN
      4'b1011: is_mul = 1'b1;
`endif
      default: res_ill = 1'b1;
    endcase
  end

  // Zero/Negative are registered together with Out so that they track the held result
  // yet read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      out_q        <= '0;
      c_q          <= 1'b0;
      v_q          <= 1'b0;
      z_q          <= 1'b0;
      n_q          <= 1'b0;
      ill_q        <= 1'b0;
`ifdef ALU_SEQ_MULT_EN
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_cnt_q    <= '0;
`endif
    end else if (accept) begin
`ifdef ALU_SEQ_MULT_EN
      if (is_mul) begin
        state_q      <= StMul;
        mul_acc_q    <= '0;
        mul_mcand_q  <= {{W{1'b0}}, A};
        mul_mplier_q <= B;
        mul_cnt_q    <= '0;
      end else
`endif
      begin
        state_q <= StDone;
        out_q   <= res;
        c_q     <= res_c;
        v_q     <= res_v;
        z_q     <= (res == '0);
        n_q     <= res[W-1];
        ill_q   <= res_ill;
      end
    end else if ((state_q == StDone) && out_ready) begin
      state_q <= StIdle;
    end
`ifdef ALU_SEQ_MULT_EN
    else if (state_q == StMul) begin
      // W shift-add steps, then one cycle to publish the product.
      if (mul_cnt_q == CNT_W'(W)) begin
        state_q <= StDone;
        out_q   <= mul_acc_q[W-1:0];
        c_q     <= mul_hi;
        v_q     <= mul_hi;
        z_q     <= (mul_acc_q[W-1:0] == '0);
        n_q     <= mul_acc_q[W-1];
        ill_q   <= 1'b0;
      end else begin
        if (mul_mplier_q[0]) begin
          mul_acc_q <= mul_acc_q + mul_mcand_q;
        end
        mul_mcand_q  <= mul_mcand_q << 1;
        mul_mplier_q <= mul_mplier_q >> 1;
        mul_cnt_q    <= mul_cnt_q + 1'b1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at W=8; follows ALU_SEQ_MULT_EN if defined.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [3:0] S = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] Out;
  logic       C_Out;
  logic       Overflow;
  logic       Zero;
  logic       Negative;
  logic       Illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seq #(.W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .S         (S),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Out       (Out),
    .C_Out     (C_Out),
    .Overflow  (Overflow),
    .Zero      (Zero),
    .Negative  (Negative),
    .Illegal   (Illegal)
  );

  // {out_valid, C_Out, Overflow, Zero, Negative, Illegal, Out}
  function automatic logic [13:0] obs();
    return {out_valid, C_Out, Overflow, Zero, Negative, Illegal, Out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    S = op;
    A = a;
    B = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    drive(4'h0, 8'h01, 8'h01);
    repeat (3) tick();
    checks++;
    if (obs() !== 14'h0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs(), 14'h0);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    tick();
    checks++;
    if (obs() !== {6'b100000, 8'h02}) begin
      failures++;
      $display("FAIL first_accept got=%h exp=%h", obs(), {6'b100000, 8'h02});
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain_to_idle got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_arith();
    logic [33:0] tbl [5];
    tbl = '{
      {4'h0, 8'hFF, 8'h01, 6'b110100, 8'h00},
      {4'h2, 8'h00, 8'h00, 6'b100000, 8'h01},
      {4'h0, 8'h7F, 8'h01, 6'b101010, 8'h80},
      {4'h1, 8'h05, 8'h07, 6'b100010, 8'hFE},
      {4'h3, 8'h10, 8'h01, 6'b110000, 8'h0E}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i][33:30], tbl[i][29:22], tbl[i][21:14]);
      tick();
      checks++;
      if (obs() !== tbl[i][13:0]) begin
        failures++;
        $display("FAIL arith[%0d] got=%h exp=%h", i, obs(), tbl[i][13:0]);
      end
    end
  endtask

  task automatic test_logic_shift();
    logic [33:0] tbl [12];
    tbl = '{
      {4'h4, 8'hF0, 8'h3C, 6'b100000, 8'h30},
      {4'h5, 8'hF0, 8'h3C, 6'b100010, 8'hFC},
      {4'h6, 8'hF0, 8'h3C, 6'b100010, 8'hCC},
      {4'h7, 8'hF0, 8'h00, 6'b100000, 8'h0F},
      {4'h4, 8'h0F, 8'hF0, 6'b100100, 8'h00},
      {4'h8, 8'h81, 8'h01, 6'b100000, 8'h02},
      {4'h9, 8'h81, 8'h03, 6'b100000, 8'h10},
      {4'hA, 8'h81, 8'h03, 6'b100010, 8'hF0},
      {4'hA, 8'h81, 8'h0F, 6'b100010, 8'hFF},
      {4'h8, 8'h81, 8'h0F, 6'b100010, 8'h80},
      {4'h9, 8'h81, 8'h0F, 6'b100000, 8'h01},
      {4'h9, 8'h81, 8'h08, 6'b100010, 8'h81}
    };
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i][33:30], tbl[i][29:22], tbl[i][21:14]);
      tick();
      checks++;
      if (obs() !== tbl[i][13:0]) begin
        failures++;
        $display("FAIL logic_shift[%0d] got=%h exp=%h", i, obs(), tbl[i][13:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_out [3];
    exp_out = '{8'h03, 8'h30, 8'hF0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: drive(4'h0, 8'h01, 8'h02);
        1: drive(4'h0, 8'h10, 8'h20);
        default: drive(4'h6, 8'hFF, 8'h0F);
      endcase
      tick();
      checks++;
      if ({out_valid, Out} !== {1'b1, exp_out[i]}) begin
        failures++;
        $display("FAIL b2b[%0d] got=%b/%h exp=1/%h", i, out_valid, Out, exp_out[i]);
      end
    end
    out_ready = 1'b0;
    drive(4'h0, 8'h40, 8'h40);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_in_ready got=%b exp=0", in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({out_valid, in_ready, Out} !== {2'b10, 8'hF0}) begin
        failures++;
        $display("FAIL stall_hold[%0d] got=%b%b/%h exp=10/f0", i, out_valid, in_ready, Out);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (obs() !== {6'b101010, 8'h80}) begin
      failures++;
      $display("FAIL stall_release got=%h exp=%h", obs(), {6'b101010, 8'h80});
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_mul();
    out_ready = 1'b1;
`ifdef ALU_SEQ_MULT_EN
    int n;
    drive(4'hB, 8'h10, 8'h20);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      A = ~A;
      B = B + 8'h33;
      S = S + 4'h1;
      tick();
      n++;
      if (n == 1) begin
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL mul_in_ready got=%b exp=0", in_ready);
        end
      end
    end
    checks++;
    if (n != 9) begin
      failures++;
      $display("FAIL mul_latency got=%0d exp=9", n);
    end
    checks++;
    if (obs() !== {6'b111100, 8'h00}) begin
      failures++;
      $display("FAIL mul_10x20 got=%h exp=%h", obs(), {6'b111100, 8'h00});
    end
    drive(4'hB, 8'h0D, 8'h0B);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (obs() !== {6'b100010, 8'h8F}) begin
      failures++;
      $display("FAIL mul_0dx0b got=%h exp=%h", obs(), {6'b100010, 8'h8F});
    end
`else
    drive(4'hB, 8'h10, 8'h20);
    tick();
    in_valid = 1'b0;
    checks++;
    if (obs() !== {6'b100101, 8'h00}) begin
      failures++;
      $display("FAIL mul_disabled got=%h exp=%h", obs(), {6'b100101, 8'h00});
    end
`endif
    tick();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(4'h0, 8'hFF, 8'h81);
    tick();
    drive(4'hC, 8'h55, 8'hAA);
    tick();
    checks++;
    if (obs() !== {6'b100101, 8'h00}) begin
      failures++;
      $display("FAIL illegal_1100 got=%h exp=%h", obs(), {6'b100101, 8'h00});
    end
    drive(4'hF, 8'hFF, 8'hFF);
    tick();
    checks++;
    if (obs() !== {6'b100101, 8'h00}) begin
      failures++;
      $display("FAIL illegal_1111 got=%h exp=%h", obs(), {6'b100101, 8'h00});
    end
    drive(4'h0, 8'h01, 8'h01);
    tick();
    checks++;
    if (obs() !== {6'b100000, 8'h02}) begin
      failures++;
      $display("FAIL illegal_clear got=%h exp=%h", obs(), {6'b100000, 8'h02});
    end
  endtask

  task automatic test_reset_mid();
    int seen;
`ifdef ALU_SEQ_MULT_EN
    out_ready = 1'b1;
    drive(4'hB, 8'h10, 8'h20);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
`else
    out_ready = 1'b0;
    drive(4'h0, 8'h7F, 8'h01);
    tick();
    in_valid = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, obs()} !== {1'b1, 14'h0}) begin
      failures++;
      $display("FAIL reset_mid got=%b/%h exp=1/0000", in_ready, obs());
    end
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (12) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_mid_no_valid got=%0d exp=0", seen);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_arith();
    test_logic_shift();
    test_back_to_back();
    test_mul();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
